reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter bit_size, default 32, data width of every register and data port; shared with the ALU operand width.
REQ-002 Parameter addr_size, default 5, register address width; depth is 2**addr_size (32 registers).
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port Read_addr_1  input  addr_size  register index for the ALU src1 operand.
REQ-006 Port Read_addr_2  input  addr_size  register index for the ALU src2 operand.
REQ-007 Port Read_data_1  output  bit_size  contents of register Read_addr_1; drives ALU src1.
REQ-008 Port Read_data_2  output  bit_size  contents of register Read_addr_2; drives ALU src2.
REQ-009 Port RegWrite  input  1  write enable for the current cycle.
REQ-010 Port Write_addr  input  addr_size  destination register index.
REQ-011 Port Write_data  input  bit_size  value to store; in the CPU this is ALU_result or the memory load data.

Function
REQ-012 Storage: 2**addr_size registers of bit_size bits each, held in flip-flops.
REQ-013 Reads: both read ports are combinational, zero latency, and independent; identical addresses on both ports return identical data.
REQ-014 Writes: at the rising clk edge with rst_n high and RegWrite=1, register Write_addr takes Write_data.
REQ-015 RegWrite=0: no register changes, whatever Write_addr and Write_data carry.
REQ-016 Register 0: reads always return 0; writes to index 0 are discarded and leave no state change.
REQ-017 Read during write to the same index: the read returns the old value in that cycle and the new value from the cycle after the edge; there is no bypass path.
REQ-018 No combinational path from Write_addr, Write_data or RegWrite to Read_data_1 or Read_data_2.
REQ-019 Read_data_1 and Read_data_2 depend only on the register state and on the read addresses.
REQ-020 Widths: all data ports are exactly bit_size bits; no sign or zero extension is done inside the block.

Reset
REQ-021 When rst_n goes low, every register clears to 0 immediately, without waiting for a clock edge.
REQ-022 While rst_n is low, Read_data_1 and Read_data_2 read 0 for every address.
REQ-023 While rst_n is low, writes are ignored.
REQ-024 A write coincident with the edge on which rst_n is low is lost.
REQ-025 Release: the first rising clk edge with rst_n high may perform a write.
REQ-026 Reset mid-operation: a write sequence interrupted by reset leaves all registers at 0; no partial state survives.

Structure
REQ-027 bit_size and addr_size defaults live in the shared CPU constants package, alongside the ALUOp encodings.
REQ-028 The index of the hard-wired-zero register (0) is a named constant in that package.
REQ-029 The block is a single flat module with no sub-modules; the register array and the per-register write decode are inline.

Verification
REQ-030 Reset check: pulse rst_n low with no clk edge, then sweep Read_addr_1 and Read_addr_2 over 0..31 -> both ports read 0x00000000 at every address.
REQ-031 Write then read: write r5=0xDEADBEEF, then set Read_addr_1=5 and Read_addr_2=5 -> both ports read 0xDEADBEEF from the cycle after the edge.
REQ-032 r0 protection: write r0=0xFFFFFFFF -> Read_data_1 at address 0 stays 0x00000000.
REQ-033 Same-cycle read/write: r7 holds 0x11111111; write r7=0x22222222 while Read_addr_2=7 -> 0x11111111 before the edge, 0x22222222 after.
REQ-034 Write-enable gating: RegWrite=0, Write_addr=9, Write_data=0x12345678 -> r9 unchanged.
REQ-035 Asynchronous clear: r3=0xA5A5A5A5; assert rst_n low between clock edges -> Read_data_1 at address 3 reads 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared CPU constants (datapath widths, hard-wired zero register, ALU op encodings).
package reg_file_pkg;

    localparam int default_bit_size  = 32;
    localparam int default_addr_size = 5;
    localparam int zero_reg          = 0;

    typedef enum logic [3:0] {
        alu_add = 4'd0,
        alu_sub = 4'd1,
        alu_and = 4'd2,
        alu_or  = 4'd3,
        alu_xor = 4'd4,
        alu_slt = 4'd5,
        alu_sll = 4'd6,
        alu_srl = 4'd7
    } alu_op_e;

endpackage

// File: rtl/reg_file.sv
// reg_file: 2**addr_size x bit_size flip-flop register file, two combinational read ports,
// one synchronous write port, register zero_reg hard-wired to zero.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int bit_size  = default_bit_size,
    parameter int addr_size = default_addr_size
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [addr_size-1:0] Read_addr_1,
    input  logic [addr_size-1:0] Read_addr_2,
    output logic [bit_size-1:0]  Read_data_1,
    output logic [bit_size-1:0]  Read_data_2,
    input  logic                 RegWrite,
    input  logic [addr_size-1:0] Write_addr,
    input  logic [bit_size-1:0]  Write_data
);

    localparam int depth = 2 ** addr_size;

    logic [bit_size-1:0] regs [depth];

    // zero_reg is never enabled, so it holds its reset value of 0 forever
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < depth; i++)
                if (RegWrite && i != zero_reg && Write_addr == addr_size'(i)) regs[i] <= Write_data;
        end
    end

    assign Read_data_1 = regs[Read_addr_1];
    assign Read_data_2 = regs[Read_addr_2];

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard-driven self-checking bench for reg_file.
`timescale 1ns/100ps
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Read_addr_1, Read_addr_2, Write_addr;
    logic [31:0] Read_data_1, Read_data_2, Write_data;
    logic        RegWrite;

    logic [31:0] sb [$];
    logic [31:0] mdl [32];
    int          vectors = 0;
    int          miscompares = 0;

    reg_file dut (
        .clk(clk), .rst_n(rst_n),
        .Read_addr_1(Read_addr_1), .Read_addr_2(Read_addr_2),
        .Read_data_1(Read_data_1), .Read_data_2(Read_data_2),
        .RegWrite(RegWrite), .Write_addr(Write_addr), .Write_data(Write_data)
    );

    always #5 clk = ~clk;

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        RegWrite = 1'b1; Write_addr = a; Write_data = d;
        @(negedge clk);
        RegWrite = 1'b0;
        if (a != 5'd0) mdl[a] = d;
    endtask

    task automatic test_reset();
        logic [31:0] e1, e2;
        RegWrite = 1'b1; Write_addr = 5'd4; Write_data = 32'hCAFE_F00D;
        #2 rst_n = 1'b0;
        #1;
        for (int a = 0; a < 32; a++) begin
            Read_addr_1 = 5'(a); Read_addr_2 = 5'(31 - a);
            sb.push_back(32'h0); sb.push_back(32'h0);
            #0.1;
            e1 = sb.pop_front(); e2 = sb.pop_front();
            vectors += 2;
            if (Read_data_1 !== e1) begin
                miscompares++;
                $display("FAIL reset_rd1 addr=%0d got=%h exp=%h", a, Read_data_1, e1);
            end
            if (Read_data_2 !== e2) begin
                miscompares++;
                $display("FAIL reset_rd2 addr=%0d got=%h exp=%h", 31 - a, Read_data_2, e2);
            end
        end
        @(negedge clk);
        Read_addr_1 = 5'd4;
        sb.push_back(32'h0);
        #1;
        e1 = sb.pop_front();
        vectors++;
        if (Read_data_1 !== e1) begin
            miscompares++;
            $display("FAIL reset_write_lost got=%h exp=%h", Read_data_1, e1);
        end
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        RegWrite = 1'b0;
        mdl[4] = 32'hCAFE_F00D;
        sb.push_back(mdl[4]);
        #1;
        e1 = sb.pop_front();
        vectors++;
        if (Read_data_1 !== e1) begin
            miscompares++;
            $display("FAIL release_first_write got=%h exp=%h", Read_data_1, e1);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] e1, e2;
        do_write(5'd5, 32'hDEAD_BEEF);
        Read_addr_1 = 5'd5; Read_addr_2 = 5'd5;
        sb.push_back(mdl[5]); sb.push_back(mdl[5]);
        #1;
        e1 = sb.pop_front(); e2 = sb.pop_front();
        vectors += 2;
        if (Read_data_1 !== e1) begin
            miscompares++;
            $display("FAIL write_read_rd1 got=%h exp=%h", Read_data_1, e1);
        end
        if (Read_data_2 !== e2) begin
            miscompares++;
            $display("FAIL write_read_rd2 got=%h exp=%h", Read_data_2, e2);
        end
    endtask

    task automatic test_r0();
        logic [31:0] e1, e2;
        do_write(5'd0, 32'hFFFF_FFFF);
        Read_addr_1 = 5'd0; Read_addr_2 = 5'd0;
        sb.push_back(32'h0); sb.push_back(32'h0);
        #1;
        e1 = sb.pop_front(); e2 = sb.pop_front();
        vectors += 2;
        if (Read_data_1 !== e1) begin
            miscompares++;
            $display("FAIL r0_rd1 got=%h exp=%h", Read_data_1, e1);
        end
        if (Read_data_2 !== e2) begin
            miscompares++;
            $display("FAIL r0_rd2 got=%h exp=%h", Read_data_2, e2);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] e;
        do_write(5'd7, 32'h1111_1111);
        @(negedge clk);
        RegWrite = 1'b1; Write_addr = 5'd7; Write_data = 32'h2222_2222; Read_addr_2 = 5'd7;
        sb.push_back(mdl[7]);
        #1;
        e = sb.pop_front();
        vectors++;
        if (Read_data_2 !== e) begin
            miscompares++;
            $display("FAIL same_cycle_old got=%h exp=%h", Read_data_2, e);
        end
        mdl[7] = 32'h2222_2222;
        sb.push_back(mdl[7]);
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (Read_data_2 !== e) begin
            miscompares++;
            $display("FAIL same_cycle_new got=%h exp=%h", Read_data_2, e);
        end
    endtask

    task automatic test_we_gating();
        logic [31:0] e;
        do_write(5'd9, 32'h0BAD_F00D);
        @(negedge clk);
        RegWrite = 1'b0; Write_addr = 5'd9; Write_data = 32'h1234_5678;
        @(negedge clk);
        Read_addr_1 = 5'd9;
        sb.push_back(mdl[9]);
        #1;
        e = sb.pop_front();
        vectors++;
        if (Read_data_1 !== e) begin
            miscompares++;
            $display("FAIL we_gating got=%h exp=%h", Read_data_1, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e1, e2;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            Read_addr_1 = 5'($urandom_range(0, 31));
            Read_addr_2 = 5'($urandom_range(0, 31));
            RegWrite    = 1'($urandom_range(0, 1));
            Write_addr  = 5'($urandom_range(0, 31));
            Write_data  = $urandom;
            sb.push_back(mdl[Read_addr_1]); sb.push_back(mdl[Read_addr_2]);
            #1;
            e1 = sb.pop_front(); e2 = sb.pop_front();
            vectors += 2;
            if (Read_data_1 !== e1) begin
                miscompares++;
                $display("FAIL b2b_rd1 n=%0d addr=%0d got=%h exp=%h", n, Read_addr_1, Read_data_1, e1);
            end
            if (Read_data_2 !== e2) begin
                miscompares++;
                $display("FAIL b2b_rd2 n=%0d addr=%0d got=%h exp=%h", n, Read_addr_2, Read_data_2, e2);
            end
            if (RegWrite && Write_addr != 5'd0) mdl[Write_addr] = Write_data;
        end
        @(negedge clk);
        RegWrite = 1'b0;
    endtask

    task automatic test_async_clear();
        logic [31:0] e1, e2;
        do_write(5'd3, 32'hA5A5_A5A5);
        do_write(5'd10, 32'h1010_1010);
        @(negedge clk);
        Read_addr_1 = 5'd3;
        sb.push_back(mdl[3]);
        #1;
        e1 = sb.pop_front();
        vectors++;
        if (Read_data_1 !== e1) begin
            miscompares++;
            $display("FAIL async_pre got=%h exp=%h", Read_data_1, e1);
        end
        RegWrite = 1'b1; Write_addr = 5'd11; Write_data = 32'h1111_0000;
        #1 rst_n = 1'b0;
        sb.push_back(32'h0);
        #1;
        e1 = sb.pop_front();
        vectors++;
        if (Read_data_1 !== e1) begin
            miscompares++;
            $display("FAIL async_clear_immediate got=%h exp=%h", Read_data_1, e1);
        end
        @(posedge clk);
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        for (int a = 0; a < 32; a++) begin
            Read_addr_1 = 5'(a); Read_addr_2 = 5'(a);
            sb.push_back(mdl[a]); sb.push_back(mdl[a]);
            #0.1;
            e1 = sb.pop_front(); e2 = sb.pop_front();
            vectors += 2;
            if (Read_data_1 !== e1) begin
                miscompares++;
                $display("FAIL midop_reset_rd1 addr=%0d got=%h exp=%h", a, Read_data_1, e1);
            end
            if (Read_data_2 !== e2) begin
                miscompares++;
                $display("FAIL midop_reset_rd2 addr=%0d got=%h exp=%h", a, Read_data_2, e2);
            end
        end
        @(negedge clk);
        RegWrite = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; RegWrite = 1'b0;
        Read_addr_1 = '0; Read_addr_2 = '0; Write_addr = '0; Write_data = '0;
        test_reset();
        test_write_read();
        test_r0();
        test_same_cycle();
        test_we_gating();
        test_back_to_back();
        test_async_clear();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
